// File: rtl/pdes_pkg.sv
// Shared definitions for the discrete-event dispatcher: event field sizes,
// dispatcher state encoding and the core-index width helper.
package pdes_pkg;

    localparam int EV_WIDTH      = 32;
    localparam int EV_TIME_WID   = 16;
    localparam int EV_NUM_CORE   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } disp_state_t;

    // A single core still needs a one-bit index.
    function automatic int core_id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/event_dispatcher_if.sv
// Command/data port between the dispatcher and the heap priority queue.
interface event_dispatcher_if #(
    parameter int WIDTH = pdes_pkg::EV_WIDTH
) ();
    logic             q_enq;
    logic             q_deq;
    logic [WIDTH-1:0] q_inp_data;
    logic [WIDTH-1:0] q_out_data;
    logic             q_full;
    logic             q_empty;

    modport master (
        output q_enq, q_deq, q_inp_data,
        input  q_out_data, q_full, q_empty
    );

    modport slave (
        input  q_enq, q_deq, q_inp_data,
        output q_out_data, q_full, q_empty
    );
endinterface

// File: rtl/event_dispatcher_rr_arbiter.sv
// Combinational round-robin pick: first requesting core at or after ptr,
// wrapping around; the pointer register lives in the caller.
module rr_arbiter
    import pdes_pkg::*;
#(
    parameter int NUM_CORE  = EV_NUM_CORE,
    parameter int CORE_ID_W = core_id_width(NUM_CORE)
) (
    input  logic [NUM_CORE-1:0]  req,
    input  logic [CORE_ID_W-1:0] ptr,
    output logic [NUM_CORE-1:0]  grant_onehot,
    output logic [CORE_ID_W-1:0] grant_idx,
    output logic                 any_grant
);

    int unsigned cand;

    // Scan from the farthest offset down so the nearest hit is written last.
    always_comb begin
        grant_idx = '0;
        any_grant = 1'b0;
        cand      = 0;
        for (int k = NUM_CORE - 1; k >= 0; k--) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_CORE) begin
                cand = cand - NUM_CORE;
            end
            if (req[cand]) begin
                any_grant = 1'b1;
                grant_idx = CORE_ID_W'(cand);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CORE; gi++) begin : g_onehot
            assign grant_onehot[gi] = any_grant && (grant_idx == CORE_ID_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/event_dispatcher.sv
// Issue stage around the heap queue: enqueues new events, dequeues the
// minimum-timestamp event to an idle core or drops it past end_time.
module event_dispatcher
    import pdes_pkg::*;
#(
    parameter int WIDTH     = EV_WIDTH,
    parameter int TIME_WID  = EV_TIME_WID,
    parameter int NUM_CORE  = EV_NUM_CORE,
    parameter int CORE_ID_W = core_id_width(NUM_CORE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [TIME_WID-1:0]   end_time,
    input  logic                  new_vld,
    input  logic [WIDTH-1:0]      new_data,
    output logic                  new_rdy,
    input  logic [NUM_CORE-1:0]   core_done,
    event_dispatcher_if.master    qif,
    output logic                  issue_vld,
    output logic [CORE_ID_W-1:0]  issue_core,
    output logic [WIDTH-1:0]      issue_data,
    output logic [NUM_CORE-1:0]   busy,
    output logic [31:0]           issued_cnt,
    output logic [15:0]           discard_cnt,
    output logic                  done
);

    disp_state_t          state_reg, state_next;
    logic                 quiet_reg, quiet_next;
    logic                 pri_reg;
    logic [CORE_ID_W-1:0] rr_ptr_reg;
    logic [NUM_CORE-1:0]  busy_reg;
    logic                 issue_vld_reg;
    logic [CORE_ID_W-1:0] issue_core_reg;
    logic [WIDTH-1:0]     issue_data_reg;
    logic [31:0]          issued_cnt_reg;
    logic [15:0]          discard_cnt_reg;

    logic [NUM_CORE-1:0]  grant_onehot;
    logic [CORE_ID_W-1:0] grant_idx;
    logic                 any_grant;
    logic [TIME_WID-1:0]  head_ts;
    logic                 in_range, run;
    logic                 deq_cand, enq_cand, conflict;
    logic                 do_issue, do_discard, quiet;

    rr_arbiter #(
        .NUM_CORE  (NUM_CORE),
        .CORE_ID_W (CORE_ID_W)
    ) u_arb (
        .req          (~busy_reg),
        .ptr          (rr_ptr_reg),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx),
        .any_grant    (any_grant)
    );

    assign head_ts  = qif.q_out_data[TIME_WID-1:0];
    assign in_range = head_ts < end_time;
    assign run      = (state_reg == ST_RUN);

    // Out-of-range heads are dropped even when every core is busy.
    assign deq_cand = !rst && run && !qif.q_empty && (!in_range || any_grant);
    assign enq_cand = !rst && new_vld && !qif.q_full;
    assign conflict = deq_cand && enq_cand;

    assign qif.q_deq      = deq_cand && !(enq_cand && pri_reg);
    assign qif.q_enq      = enq_cand && !(deq_cand && !pri_reg);
    assign qif.q_inp_data = new_data;
    assign new_rdy        = qif.q_enq;

    assign do_issue   = qif.q_deq && in_range;
    assign do_discard = qif.q_deq && !in_range;

    assign quiet = qif.q_empty && (busy_reg == '0) && !new_vld
                   && !issue_vld_reg && !qif.q_enq;

    always_comb begin
        state_next = state_reg;
        quiet_next = 1'b0;
        case (state_reg)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN: begin
                if (quiet) begin
                    if (quiet_reg) state_next = ST_DONE;
                    else           quiet_next = 1'b1;
                end
            end
            ST_DONE: if (start) state_next = ST_RUN;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            quiet_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            quiet_reg <= quiet_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pri_reg         <= 1'b0;
            rr_ptr_reg      <= '0;
            busy_reg        <= '0;
            issue_vld_reg   <= 1'b0;
            issue_core_reg  <= '0;
            issue_data_reg  <= '0;
            issued_cnt_reg  <= '0;
            discard_cnt_reg <= '0;
        end else begin
            if (conflict) pri_reg <= ~pri_reg;
            busy_reg      <= (busy_reg & ~core_done) | (do_issue ? grant_onehot : '0);
            issue_vld_reg <= do_issue;
            if (do_issue) begin
                issue_core_reg <= grant_idx;
                issue_data_reg <= qif.q_out_data;
                issued_cnt_reg <= issued_cnt_reg + 32'd1;
                rr_ptr_reg     <= (grant_idx == CORE_ID_W'(NUM_CORE - 1))
                                  ? '0 : grant_idx + 1'b1;
            end
            if (do_discard) discard_cnt_reg <= discard_cnt_reg + 16'd1;
        end
    end

    assign issue_vld   = issue_vld_reg;
    assign issue_core  = issue_core_reg;
    assign issue_data  = issue_data_reg;
    assign busy        = busy_reg;
    assign issued_cnt  = issued_cnt_reg;
    assign discard_cnt = discard_cnt_reg;
    assign done        = (state_reg == ST_DONE);

endmodule

// File: tb/tb_event_dispatcher.sv
// Scoreboarded bench: a behavioural min-queue stands in for the heap and a
// monitor checks every issued event against the expected-issue queue.
module tb_event_dispatcher;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] end_time = 16'd1000;
    logic        new_vld = 1'b0;
    logic [31:0] new_data = '0;
    logic        new_rdy;
    logic [3:0]  core_done = '0;
    logic        issue_vld;
    logic [1:0]  issue_core;
    logic [31:0] issue_data;
    logic [3:0]  busy;
    logic [31:0] issued_cnt;
    logic [15:0] discard_cnt;
    logic        done;

    event_dispatcher_if #(.WIDTH(32)) qif ();

    event_dispatcher dut (
        .clk (clk), .rst (rst), .start (start), .end_time (end_time),
        .new_vld (new_vld), .new_data (new_data), .new_rdy (new_rdy),
        .core_done (core_done), .qif (qif),
        .issue_vld (issue_vld), .issue_core (issue_core), .issue_data (issue_data),
        .busy (busy), .issued_cnt (issued_cnt), .discard_cnt (discard_cnt), .done (done)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Behavioural heap: sorted by timestamp, updated just after each edge.
    logic [31:0] mq[$];
    logic [31:0] head_v = '0;
    logic        empty_v = 1'b1;
    logic        force_full = 1'b0;
    int          deq_count = 0;
    int          deq_at_force = 0;
    logic        m_en, m_de, m_rst;
    logic [31:0] m_d;
    int          pos;

    assign qif.q_out_data = head_v;
    assign qif.q_empty    = empty_v;
    assign qif.q_full     = force_full && (deq_count == deq_at_force);

    always @(posedge clk) begin
        m_en = qif.q_enq; m_de = qif.q_deq; m_d = qif.q_inp_data; m_rst = rst;
        #1;
        if (m_rst) begin
            mq.delete();
        end else begin
            if (m_de && mq.size() > 0) begin
                void'(mq.pop_front());
                deq_count++;
            end
            if (m_en) begin
                pos = mq.size();
                for (int i = 0; i < mq.size(); i++) begin
                    if (mq[i][15:0] > m_d[15:0]) begin pos = i; break; end
                end
                mq.insert(pos, m_d);
            end
        end
        head_v  = (mq.size() > 0) ? mq[0] : 32'd0;
        empty_v = (mq.size() == 0);
    end

    typedef struct { logic [1:0] core; logic [31:0] data; } exp_t;
    exp_t exp_q[$];

    task automatic expect_issue(input logic [1:0] c, input logic [31:0] d);
        exp_t e;
        e.core = c; e.data = d;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (issue_vld) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_issue: got core %0d data %0h expected none", issue_core, issue_data);
            end else begin
                e = exp_q.pop_front();
                check("issue_core", issue_core, e.core);
                check("issue_data", issue_data, e.data);
                $display("issue core=%0d data=%0d", issue_core, issue_data);
            end
        end
    end

    // Offer one event and hold it until accepted; returns on a negedge.
    task automatic send(input logic [31:0] d, input bit chk_now, input string nm);
        int n = 0;
        new_vld = 1'b1; new_data = d;
        #1;
        if (chk_now) check(nm, new_rdy, 1);
        while (!new_rdy && n < 20) begin @(negedge clk); #1; n++; end
        if (!new_rdy) begin
            total_cnt++;
            $display("FAIL send_timeout: got new_rdy 0 expected 1 for data %0d", d);
        end
        @(negedge clk);
        new_vld = 1'b0;
        $display("enq data=%0d", d);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_issue_vld", issue_vld, 0);
        check("rst_busy", busy, 0);
        check("rst_issued_cnt", issued_cnt, 0);
        check("rst_discard_cnt", discard_cnt, 0);
        check("rst_issue_core", issue_core, 0);
        check("rst_issue_data", issue_data, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        @(negedge clk);

        // Ordered issue to cores 0,1,2.
        expect_issue(2'd0, 32'd10);
        expect_issue(2'd1, 32'd20);
        expect_issue(2'd2, 32'd30);
        send(32'd30, 1, "idle_enq_rdy");
        send(32'd10, 1, "idle_enq_rdy");
        send(32'd20, 1, "idle_enq_rdy");
        pulse_start();
        repeat (5) @(negedge clk);
        check("t1_issued_cnt", issued_cnt, 3);
        check("t1_busy", busy, 4'b0111);

        // Discard beyond end_time; 10 goes to core3.
        end_time = 16'd25;
        expect_issue(2'd3, 32'd10);
        send(32'd10, 0, "");
        send(32'd40, 0, "");
        repeat (4) @(negedge clk);
        check("t2_discard_cnt", discard_cnt, 1);
        check("t2_issued_cnt", issued_cnt, 4);
        check("t2_busy", busy, 4'b1111);

        // All busy: only enqueues; freeing core2 redirects the next issue.
        end_time = 16'd1000;
        send(32'd50, 1, "busy_enq_rdy");
        send(32'd60, 1, "busy_enq_rdy");
        send(32'd70, 1, "busy_enq_rdy");
        expect_issue(2'd2, 32'd50);
        core_done = 4'b0100;
        @(negedge clk);
        core_done = 4'b0000;
        #1 check("t3_deq_after_done", qif.q_deq, 1);
        repeat (3) @(negedge clk);

        // Conflict alternation after reset: deq first.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("t4_reset_clears_scoreboard", exp_q.size(), 0);
        send(32'd5, 0, "");
        send(32'd6, 0, "");
        send(32'd7, 0, "");
        expect_issue(2'd0, 32'd5);
        expect_issue(2'd1, 32'd6);
        expect_issue(2'd2, 32'd7);
        expect_issue(2'd3, 32'd101);
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            new_vld = 1'b1; new_data = 32'd100 + 32'(i);
            #1;
            check("t4_alt_deq", qif.q_deq, ((i % 2) == 0) ? 1 : 0);
            check("t4_alt_enq", qif.q_enq, ((i % 2) == 1) ? 1 : 0);
            @(negedge clk);
        end
        new_vld = 1'b0;
        repeat (3) @(negedge clk);
        check("t4_busy", busy, 4'b1111);

        // Full queue blocks enqueue until a dequeue frees room.
        force_full = 1'b1; deq_at_force = deq_count;
        new_vld = 1'b1; new_data = 32'd200;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t5_full_rdy", new_rdy, 0);
            check("t5_full_enq", qif.q_enq, 0);
            @(negedge clk);
        end
        expect_issue(2'd1, 32'd103);
        core_done = 4'b0010;
        #1 check("t5_full_rdy", new_rdy, 0);
        @(negedge clk);
        core_done = 4'b0000;
        #1;
        check("t5_deq", qif.q_deq, 1);
        check("t5_full_rdy", new_rdy, 0);
        @(negedge clk);
        #1 check("t5_room_rdy", new_rdy, 1);
        @(negedge clk);
        new_vld = 1'b0; force_full = 1'b0;
        $display("enq data=200");

        // Drain and detect completion.
        expect_issue(2'd2, 32'd105);
        expect_issue(2'd3, 32'd200);
        core_done = 4'b1111;
        @(negedge clk);
        core_done = 4'b0000;
        repeat (4) @(negedge clk);
        check("t6_busy", busy, 4'b1100);
        check("t6_issued_cnt", issued_cnt, 7);
        check("t6_discard_cnt", discard_cnt, 0);
        core_done = 4'b1100;
        @(negedge clk);
        core_done = 4'b0000;
        check("t6_busy_clear", busy, 0);
        check("t6_done_q1", done, 0);
        @(negedge clk);
        check("t6_done_q2", done, 0);
        @(negedge clk);
        check("t6_done", done, 1);

        // Restart, then reset while an issue is pending.
        send(32'd300, 1, "done_enq_rdy");
        check("t6_done_hold", done, 1);
        pulse_start();
        #1 check("t7_deq_pending", qif.q_deq, 1);
        rst = 1'b1;
        @(negedge clk);
        check("t7_issue_vld", issue_vld, 0);
        check("t7_busy", busy, 0);
        check("t7_issued_cnt", issued_cnt, 0);
        check("t7_done", done, 0);
        rst = 1'b0;
        send(32'd400, 1, "t7_idle_enq_rdy");
        #1 check("t7_idle_no_deq", qif.q_deq, 0);
        @(negedge clk);
        check("final_scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/event_dispatcher.md
Name: event_dispatcher

Overview:
- Command controller and issue stage wrapped around the heap priority queue. It owns the queue's single enq/deq command port.
- It accepts newly generated events from the cores and enqueues them.
- It dequeues the minimum-timestamp event and issues it to an idle core, chosen round-robin.
- Events at or beyond the simulation end time are dropped. It detects global completion of the simulation run.

Parameters:
WIDTH, 32, event word width; equals queue WIDTH
TIME_WID, 16, timestamp field = event[TIME_WID-1:0]; equals queue CMP_WID
NUM_CORE, 4, number of event-processing cores
CORE_ID_W, 2, width of core index; equals clog2(NUM_CORE)

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  pulse; IDLE->RUN or DONE->RUN
end_time  in  TIME_WID  events with timestamp >= end_time are discarded
new_vld  in  1  new event offered by cores
new_data  in  WIDTH  new event word
new_rdy  out  1  new event accepted this cycle (transfer = new_vld & new_rdy)
core_done  in  NUM_CORE  per-core one-cycle pulse: core finished its event
q_enq  out  1  queue enqueue command
q_deq  out  1  queue dequeue command
q_inp_data  out  WIDTH  queue input data (= new_data)
q_out_data  in  WIDTH  queue head (minimum)
q_full  in  1  queue full
q_empty  in  1  queue empty
issue_vld  out  1  one-cycle pulse: event issued
issue_core  out  CORE_ID_W  target core
issue_data  out  WIDTH  issued event
busy  out  NUM_CORE  per-core busy vector
issued_cnt  out  32  events issued since reset (wraps)
discard_cnt  out  16  events discarded since reset (wraps)
done  out  1  level; high in DONE state

Behaviour:
- Reset (rst=1 at edge): state=IDLE, busy=0, rr_ptr=0, pri=0 (deq first), issue_vld=0, issue_core=0, issue_data=0, counters=0, quiet counter=0. The queue is reset by its own reset; the dispatcher never depends on queue contents across reset.
- At most one queue command per cycle; q_enq and q_deq are never both 1. Both are combinational from registered state and current inputs.
- enq candidate: new_vld & !q_full, in any state except reset.
- deq candidate, state RUN and !q_empty:
  - issue path: head timestamp < end_time and some core has busy=0.
  - discard path: head timestamp >= end_time (no idle core needed).
- Timestamp compare is unsigned on TIME_WID bits.
- Conflict (both candidates):
  - pri=0 serves deq; pri=1 serves enq.
  - pri toggles only on a conflict cycle.
  - No conflict: the single candidate is served.
- new_rdy = q_enq.
- Issue latency: deq at cycle t samples q_out_data at t. At the t+1 edge: issue_vld=1, issue_data=sampled head, issue_core=grant, busy[grant]=1, rr_ptr=grant+1 mod NUM_CORE, issued_cnt+1. issue_vld returns to 0 next cycle unless another issue occurs (back-to-back deqs allowed).
- Discard: deq as above, no issue_vld, no busy change, discard_cnt+1.
- Round-robin: grant = first core with busy=0, searching from rr_ptr upward with wrap.
- busy uses registered values. core_done[i] clears busy[i] at the next edge. core_done on a non-busy core is ignored. A core freed at t is eligible at t+1.
- Cores present any new events (new_vld) no later than the cycle of their core_done.
- FSM:
  - IDLE: enq only, no deq. start -> RUN.
  - RUN: quiet = q_empty & busy==0 & !new_vld & !issue_vld & !q_enq. Two consecutive quiet cycles -> DONE. Any non-quiet cycle clears the quiet counter.
  - DONE: done=1, enq still accepted, no deq. start -> RUN with quiet counter cleared.
- start in RUN is ignored.
- rst mid-operation aborts the in-flight issue: issue_vld=0 next cycle.

Decomposition:
- pdes_pkg holds:
  - event-field constants (TIME_WID, event WIDTH)
  - the FSM state encoding (IDLE, RUN, DONE)
  - the core-id width function
- Sub-module rr_arbiter (NUM_CORE request vector + pointer -> one-hot/indexed grant + any_grant), purely combinational; pointer register stays in event_dispatcher.

Test Plan:
- Reset, enqueue ts 30,10,20 in IDLE, start, NUM_CORE=4 all idle -> issues ts 10 to core0, 20 to core1, 30 to core2 on consecutive cycles; issued_cnt=3, busy=0111.
- end_time=25, queue holds ts 10,40 -> ts 10 issued, ts 40 dequeued with no issue_vld; discard_cnt=1.
- All cores busy, queue non-empty, new_vld steady -> only enqs (new_rdy=1 each cycle); core_done[2] -> next dispatch goes to core2.
- Conflict every cycle (new_vld=1, idle cores, non-empty queue) -> deq, enq, deq, enq alternation starting with deq after reset.
- q_full=1 with new_vld=1 -> new_rdy=0, q_enq=0 until a deq occurs.
- Run to completion: last core_done with empty queue and no new_vld -> done=1 exactly 2 cycles later; rst asserted while issue pending -> issue_vld=0, busy=0, state IDLE.
